// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode constants: the canonical NOP encoding, instruction width
// and the sequential PC increment used by the fetch front end and its users.
package fetch_buffer_pkg;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned PC_STEP    = 4;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a single-cycle flush.
// Ports: clock/reset (sync, active-high), flush clears all entries, push/push_data
// write the tail, pop removes the head, head_data/count/empty/full report state.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: issues sequential PC requests to instruction
// memory under a credit limit, queues returned words tagged with their PCs and
// presents them to decode; a decode redirect flushes the queue and discards
// wrong-path words still in flight.
// Ports: clock/reset (sync, active-high); imem_req_* request channel;
// imem_resp_* in-order response channel; inst_valid/inst/inst_PC/inst_ready
// decode handshake; next_PC_select/target_PC redirect from decode.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned             ADDRESS_BITS = 16,
    parameter int unsigned             DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [INST_WIDTH-1:0]   imem_resp_data,
    output logic                    inst_valid,
    output logic [INST_WIDTH-1:0]   inst,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    input  logic                    inst_ready,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ADDRESS_BITS + INST_WIDTH;

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           discard_q, discard_d;

    logic [EW-1:0]           head_data;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty, fifo_full;
    logic                    handshake, redirect, credit_ok, req_fire, resp_keep;

    // Credits, redirect and PC bookkeeping.
    always_comb begin
        handshake     = !fifo_empty && inst_ready;
        redirect      = handshake && next_PC_select;
        // Queued plus in-flight words may never exceed the queue depth.
        credit_ok     = ((CW+1)'(fifo_count) + (CW+1)'(outstanding_q)) < (CW+1)'(DEPTH);
        imem_req_valid = !reset && !redirect && credit_ok;
        req_fire      = imem_req_valid && imem_req_ready;
        resp_keep     = imem_resp_valid && (discard_q == '0) && !redirect;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (redirect) begin
            // Every word still in flight is wrong-path, including one landing now.
            fetch_pc_d = target_PC & ~ADDRESS_BITS'(3);
            resp_pc_d  = target_PC & ~ADDRESS_BITS'(3);
            discard_d  = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire)  fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(PC_STEP);
            if (resp_keep) resp_pc_d  = resp_pc_q + ADDRESS_BITS'(PC_STEP);
            if (imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (resp_keep),
        .push_data ({resp_pc_q, imem_resp_data}),
        .pop       (handshake),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign imem_req_addr = fetch_pc_q;
    assign inst_valid    = !fifo_empty;
    assign inst          = fifo_empty ? NOP_INST : head_data[INST_WIDTH-1:0];
    assign inst_PC       = fifo_empty ? '0 : head_data[EW-1:INST_WIDTH];

    // Credit accounting makes a response into a full queue a memory protocol error.
    assert property (@(posedge clock) disable iff (reset) !(imem_resp_valid && fifo_full));

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: an in-order latency memory model plus an epoch-based
// reference of the instruction stream, driven with directed and random stimulus.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int unsigned AB    = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct { logic [AB-1:0] addr; int due; int ep; } mreq_t;
    typedef struct { logic [AB-1:0] pc; logic [31:0] w; } ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          req_valid, req_ready, resp_valid, inst_valid, inst_ready, sel;
    logic [AB-1:0] req_addr, inst_pc, target;
    logic [31:0]   resp_data, inst_w;

    logic          req_valid1, req_ready1, resp_valid1, inst_valid1, inst_ready1, sel1;
    logic [AB-1:0] req_addr1, inst_pc1, target1;
    logic [31:0]   resp_data1, inst_w1;

    fetch_buffer #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .inst_valid(inst_valid), .inst(inst_w), .inst_PC(inst_pc), .inst_ready(inst_ready),
        .next_PC_select(sel), .target_PC(target)
    );

    fetch_buffer #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(16'hFFF8)) dut_wrap (
        .clock(clock), .reset(reset),
        .imem_req_valid(req_valid1), .imem_req_addr(req_addr1), .imem_req_ready(req_ready1),
        .imem_resp_valid(resp_valid1), .imem_resp_data(resp_data1),
        .inst_valid(inst_valid1), .inst(inst_w1), .inst_PC(inst_pc1), .inst_ready(inst_ready1),
        .next_PC_select(sel1), .target_PC(target1)
    );

    // Reference state
    mreq_t         memq[$];
    ent_t          iq[$];
    logic [AB-1:0] deliv[$];
    logic [AB-1:0] reqs[$];
    logic [AB-1:0] nf;
    int            cyc, lat, epoch, last_due, first_valid, mm_cnt;
    int            n_pass, n_total;

    function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // One cycle: present memory response and decode inputs, compare DUT against the model, advance.
    task automatic step(input logic ir, input logic want_redir, input logic [AB-1:0] tgt, input logic rdy);
        mreq_t         m;
        logic          rsp, hs, redir, exp_rv;
        logic [AB-1:0] rsp_addr;
        int            rsp_ep, d;
        rsp = 1'b0; rsp_addr = '0; rsp_ep = -1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            rsp = 1'b1; rsp_addr = m.addr; rsp_ep = m.ep;
        end
        resp_valid = rsp;
        resp_data  = rsp ? mem_word(rsp_addr) : $urandom;
        hs         = ir && (iq.size() > 0);
        redir      = hs && want_redir;
        inst_ready = ir;
        sel        = hs ? redir : 1'($urandom_range(0, 1));
        target     = tgt;
        req_ready  = rdy;
        #1;
        exp_rv = !redir && ((iq.size() + memq.size() + int'(rsp)) < DEPTH);
        if (req_valid !== exp_rv) mm_cnt++;
        if (exp_rv && req_addr !== nf) mm_cnt++;
        if (iq.size() > 0) begin
            if (inst_valid !== 1'b1 || inst_w !== iq[0].w || inst_pc !== iq[0].pc) mm_cnt++;
        end else begin
            if (inst_valid !== 1'b0 || inst_w !== NOP_INST || inst_pc !== 16'h0000) mm_cnt++;
        end
        if (inst_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (exp_rv && rdy) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq.push_back('{addr: nf, due: d, ep: epoch});
            reqs.push_back(nf);
            nf = nf + 16'd4;
        end
        if (hs) begin
            deliv.push_back(iq[0].pc);
            void'(iq.pop_front());
        end
        if (rsp && rsp_ep == epoch && !redir) iq.push_back('{pc: rsp_addr, w: mem_word(rsp_addr)});
        if (redir) begin
            iq.delete();
            epoch++;
            nf = tgt & 16'hFFFC;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset(input int ncyc, input logic resp_in_reset);
        reset = 1'b1;
        inst_ready = 1'b0; sel = 1'b0; req_ready = 1'b0; target = '0;
        resp_valid = resp_in_reset; resp_data = $urandom;
        inst_ready1 = 1'b0; sel1 = 1'b0; req_ready1 = 1'b0; resp_valid1 = 1'b0;
        repeat (ncyc) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b0;
        resp_valid = 1'b0;
        memq.delete(); iq.delete(); deliv.delete(); reqs.delete();
        epoch++; nf = 16'h0000; cyc = 1; last_due = 0; first_valid = -1; mm_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_total++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid_in_reset: got %0b expected 0", req_valid); else n_pass++;
        do_reset(2, 1'b0);
        #1;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %0b expected 0", inst_valid); else n_pass++;
        n_total++; if (inst_w !== NOP_INST) $display("FAIL reset_inst: got %h expected %h", inst_w, NOP_INST); else n_pass++;
        n_total++; if (inst_pc !== 16'h0000) $display("FAIL reset_inst_pc: got %h expected 0000", inst_pc); else n_pass++;
        n_total++; if (req_valid !== 1'b1) $display("FAIL reset_req_valid: got %0b expected 1", req_valid); else n_pass++;
        n_total++; if (req_addr !== 16'h0000) $display("FAIL reset_req_addr: got %h expected 0000", req_addr); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset(1, 1'b0);
        lat = 1;
        repeat (14) step(1'b1, 1'b0, '0, 1'b1);
        n_total++; if (mm_cnt !== 0) $display("FAIL stream_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
        n_total++; if (first_valid !== 3) $display("FAIL stream_first_valid_cycle: got %0d expected 3", first_valid); else n_pass++;
        n_total++; if (deliv.size() < 8) $display("FAIL stream_count: got %0d expected >=8", deliv.size()); else n_pass++;
        for (int i = 0; i < 8 && i < deliv.size(); i++) begin
            n_total++;
            if (deliv[i] !== 16'(4 * i)) $display("FAIL stream_pc%0d: got %h expected %h", i, deliv[i], 16'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        lat = 1;
        repeat (10) step(1'b0, 1'b0, '0, 1'b1);
        n_total++; if (reqs.size() !== 4) $display("FAIL bp_req_count: got %0d expected 4", reqs.size()); else n_pass++;
        for (int i = 0; i < 4 && i < reqs.size(); i++) begin
            n_total++;
            if (reqs[i] !== 16'(4 * i)) $display("FAIL bp_req%0d: got %h expected %h", i, reqs[i], 16'(4 * i));
            else n_pass++;
        end
        n_total++; if (req_valid !== 1'b0) $display("FAIL bp_req_held: got %0b expected 0", req_valid); else n_pass++;
        repeat (10) step(1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (reqs.size() < 5 || reqs[4] !== 16'h0010) $display("FAIL bp_resume_addr: got %h expected 0010", reqs.size() >= 5 ? reqs[4] : 16'hxxxx);
        else n_pass++;
        n_total++;
        if (deliv.size() < 4 || deliv[3] !== 16'h000C) $display("FAIL bp_drain_order: got %h expected 000c", deliv.size() >= 4 ? deliv[3] : 16'hxxxx);
        else n_pass++;
        n_total++; if (mm_cnt !== 0) $display("FAIL bp_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
    endtask

    // Returns the PC delivered right after the first delivery of pc, or DEAD if none.
    function automatic logic [AB-1:0] pc_after(input logic [AB-1:0] pc);
        for (int i = 0; i + 1 < deliv.size(); i++)
            if (deliv[i] == pc) return deliv[i + 1];
        return 16'hDEAD;
    endfunction

    task automatic test_redirect_inflight();
        do_reset(1, 1'b0);
        lat = 1;
        repeat (6) step(1'b1, iq.size() > 0 && iq[0].pc == 16'h0000, 16'h0100, 1'b1);
        lat = 3;
        repeat (40) step(1'b1, iq.size() > 0 && iq[0].pc == 16'h0114, 16'h0128, 1'b1);
        n_total++; if (pc_after(16'h0000) !== 16'h0100) $display("FAIL redir1_next_pc: got %h expected 0100", pc_after(16'h0000)); else n_pass++;
        n_total++; if (pc_after(16'h0114) !== 16'h0128) $display("FAIL redir2_next_pc: got %h expected 0128", pc_after(16'h0114)); else n_pass++;
        n_total++; if (mm_cnt !== 0) $display("FAIL redir_inflight_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
    endtask

    task automatic test_redirect_resp();
        do_reset(1, 1'b0);
        lat = 1;
        repeat (14) step(1'b1, iq.size() > 0 && iq[0].pc == 16'h0008, 16'h0043, 1'b1);
        n_total++; if (pc_after(16'h0008) !== 16'h0040) $display("FAIL redir_resp_next_pc: got %h expected 0040", pc_after(16'h0008)); else n_pass++;
        n_total++; if (mm_cnt !== 0) $display("FAIL redir_resp_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
    endtask

    task automatic test_reset_midop();
        do_reset(1, 1'b0);
        lat = 3;
        repeat (5) step(1'b0, 1'b0, '0, 1'b1);
        n_total++; if (inst_valid !== 1'b1) $display("FAIL midop_prefill: got %0b expected 1", inst_valid); else n_pass++;
        do_reset(1, 1'b1);
        #1;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL midop_inst_valid: got %0b expected 0", inst_valid); else n_pass++;
        n_total++; if (inst_w !== NOP_INST) $display("FAIL midop_inst: got %h expected %h", inst_w, NOP_INST); else n_pass++;
        n_total++; if (req_addr !== 16'h0000) $display("FAIL midop_req_addr: got %h expected 0000", req_addr); else n_pass++;
        lat = 1;
        repeat (10) step(1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (deliv.size() < 1 || deliv[0] !== 16'h0000) $display("FAIL midop_first_pc: got %h expected 0000", deliv.size() >= 1 ? deliv[0] : 16'hxxxx);
        else n_pass++;
        n_total++; if (mm_cnt !== 0) $display("FAIL midop_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
    endtask

    task automatic test_random();
        logic want;
        do_reset(1, 1'b0);
        lat = 2;
        for (int c = 0; c < 500; c++) begin
            if (c % 50 == 0) lat = $urandom_range(1, 4);
            want = ($urandom_range(0, 7) == 0);
            step(1'($urandom_range(0, 3) != 0), want, 16'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        n_total++; if (mm_cnt !== 0) $display("FAIL random_model: %0d cycle mismatches, expected 0", mm_cnt); else n_pass++;
        n_total++; if (deliv.size() < 50) $display("FAIL random_progress: got %0d deliveries expected >=50", deliv.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [AB-1:0] got[$];
        logic          pend;
        logic [AB-1:0] pend_addr;
        int            bad;
        do_reset(1, 1'b0);
        pend = 1'b0; pend_addr = '0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            resp_valid1 = pend;
            resp_data1  = mem_word(pend_addr);
            req_ready1  = 1'b1;
            inst_ready1 = 1'b1;
            #1;
            if (inst_valid1 === 1'b1) begin
                got.push_back(inst_pc1);
                if (inst_w1 !== mem_word(inst_pc1)) bad++;
            end
            pend = req_valid1;
            pend_addr = req_addr1;
            @(posedge clock);
            @(negedge clock);
        end
        resp_valid1 = 1'b0; req_ready1 = 1'b0; inst_ready1 = 1'b0;
        n_total++; if (got.size() < 4) $display("FAIL wrap_count: got %0d expected >=4", got.size()); else n_pass++;
        if (got.size() >= 4) begin
            n_total++; if (got[0] !== 16'hFFF8) $display("FAIL wrap_pc0: got %h expected fff8", got[0]); else n_pass++;
            n_total++; if (got[1] !== 16'hFFFC) $display("FAIL wrap_pc1: got %h expected fffc", got[1]); else n_pass++;
            n_total++; if (got[2] !== 16'h0000) $display("FAIL wrap_pc2: got %h expected 0000", got[2]); else n_pass++;
            n_total++; if (got[3] !== 16'h0004) $display("FAIL wrap_pc3: got %h expected 0004", got[3]); else n_pass++;
        end
        n_total++; if (bad !== 0) $display("FAIL wrap_data: %0d wrong words, expected 0", bad); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; epoch = 0; lat = 1;
        reset = 1'b1;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0; sel = 1'b0; target = '0;
        req_ready1 = 1'b0; resp_valid1 = 1'b0; resp_data1 = '0; inst_ready1 = 1'b0; sel1 = 1'b0; target1 = '0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_resp();
        test_reset_midop();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
